// File: rtl/hvtx_box_gen.sv
`timescale 1ns/1ps
// hvtx_box_gen: moving-box test pattern.
// Takes the cursor coordinates and sync strobes from the timing generator and
// draws a BOX_SIZE square over a flat background. The square bounces inside the
// active area and advances once every FRAMES_PER_STEP frames.
// hs/vs/de and video all have a fixed 3-cycle latency from the inputs.
// The box only moves in the cycle after a vsync rising edge, which falls in
// vertical blanking, so a frame is never drawn with two box positions.
module hvtx_box_gen #(
  parameter int          WID             = 12,
  parameter int          ACTIVE_WIDTH    = 1920,
  parameter int          ACTIVE_HEIGHT   = 1080,
  parameter int          BOX_SIZE        = 10,
  parameter int          STEP            = 10,
  parameter int          FRAMES_PER_STEP = 1,
  parameter logic [23:0] FG_COLOR        = 24'h00f0f0,
  parameter logic [23:0] BG_COLOR        = 24'hc0c0c0
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_en,
  input  logic [WID-1:0] i_x,
  input  logic [WID-1:0] i_y,
  input  logic           i_hs,
  input  logic           i_vs,
  input  logic           i_de,
  output logic           o_hs,
  output logic           o_vs,
  output logic           o_de,
  output logic [23:0]    o_video,
  output logic [WID-1:0] o_box_x,
  output logic [WID-1:0] o_box_y
);

  // Frame counter width; a single-frame step still gets one (constant) bit.
  localparam int             FCW     = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
  localparam logic [FCW-1:0] FC_LAST = FCW'(FRAMES_PER_STEP - 1);

  // Position arithmetic is one bit wider than the coordinates so that
  // pos+STEP and pos+BOX_SIZE can never wrap.
  localparam logic [WID:0]   BOX_W   = (WID+1)'(BOX_SIZE);
  localparam logic [WID:0]   STEP_W  = (WID+1)'(STEP);

  // ------------------------------------------------------------------
  // Frame tick and step decision
  // ------------------------------------------------------------------
  logic           vs_prev_q;
  logic           vs_rise;
  logic [FCW-1:0] frame_cnt_q;
  logic [FCW-1:0] frame_cnt_d;
  logic           step_now;

  // Previous vsync sample, used for rising-edge detection.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      vs_prev_q <= 1'b0;
    end else begin
      vs_prev_q <= i_vs;
    end
  end

  // One tick per vsync rise; a step fires when the frame count wraps.
  always_comb begin
    vs_rise     = i_vs & ~vs_prev_q;
    frame_cnt_d = frame_cnt_q;
    step_now    = 1'b0;
    if (vs_rise && i_en) begin
      if (frame_cnt_q == FC_LAST) begin
        frame_cnt_d = '0;
        step_now    = 1'b1;
      end else begin
        frame_cnt_d = frame_cnt_q + 1'b1;
      end
    end
  end

  // Frame counter register; frozen while movement is disabled.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      frame_cnt_q <= '0;
    end else begin
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // ------------------------------------------------------------------
  // Per-axis box position, direction and stage-1 coordinate.
  // Axis 0 is x (horizontal), axis 1 is y (vertical).
  // ------------------------------------------------------------------
  logic [WID-1:0] axis_in  [2];
  logic [WID-1:0] box_pos  [2];
  logic           axis_hit [2];

  assign axis_in[0] = i_x;
  assign axis_in[1] = i_y;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : gen_axis
      localparam int           ACTIVE = (gi == 0) ? ACTIVE_WIDTH : ACTIVE_HEIGHT;
      localparam logic [WID:0] MAX_W  = (WID+1)'(ACTIVE - BOX_SIZE);

      logic [WID-1:0] pos_q;
      logic [WID-1:0] pos_d;
      logic           neg_q;
      logic           neg_d;
      logic [WID-1:0] coord_s1_q;
      logic [WID:0]   pos_ext;
      logic [WID:0]   fwd_sum;
      logic [WID:0]   coord_ext;

      // Bounce rule: clamp to the edge and reverse when the next step
      // would reach or pass it, otherwise move by STEP.
      always_comb begin
        pos_ext = {1'b0, pos_q};
        fwd_sum = pos_ext + STEP_W;
        pos_d   = pos_q;
        neg_d   = neg_q;
        if (step_now) begin
          if (!neg_q) begin
            if (fwd_sum >= MAX_W) begin
              pos_d = MAX_W[WID-1:0];
              neg_d = 1'b1;
            end else begin
              pos_d = fwd_sum[WID-1:0];
            end
          end else begin
            if (pos_ext <= STEP_W) begin
              pos_d = '0;
              neg_d = 1'b0;
            end else begin
              pos_d = pos_q - STEP_W[WID-1:0];
            end
          end
        end
      end

      // Box edge and direction registers; start at the origin heading +.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          pos_q <= '0;
          neg_q <= 1'b0;
        end else begin
          pos_q <= pos_d;
          neg_q <= neg_d;
        end
      end

      // Stage 1: register the incoming coordinate for this axis.
      always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
          coord_s1_q <= '0;
        end else begin
          coord_s1_q <= axis_in[gi];
        end
      end

      // Half-open range test [pos, pos+BOX_SIZE) in the widened domain.
      assign coord_ext    = {1'b0, coord_s1_q};
      assign axis_hit[gi] = (coord_ext >= pos_ext) && (coord_ext < (pos_ext + BOX_W));
      assign box_pos[gi]  = pos_q;
    end
  endgenerate

  assign o_box_x = box_pos[0];
  assign o_box_y = box_pos[1];

  // ------------------------------------------------------------------
  // Sync pipeline and colour selection
  // ------------------------------------------------------------------
  logic s1_hs_q, s1_vs_q, s1_de_q;
  logic s2_hs_q, s2_vs_q, s2_de_q;
  logic s2_in_box_q;

  // Stage 1: register the sync strobes alongside the coordinates.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_hs_q <= 1'b0;
      s1_vs_q <= 1'b0;
      s1_de_q <= 1'b0;
    end else begin
      s1_hs_q <= i_hs;
      s1_vs_q <= i_vs;
      s1_de_q <= i_de;
    end
  end

  // Stage 2: capture the box hit for the stage-1 pixel.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s2_hs_q     <= 1'b0;
      s2_vs_q     <= 1'b0;
      s2_de_q     <= 1'b0;
      s2_in_box_q <= 1'b0;
    end else begin
      s2_hs_q     <= s1_hs_q;
      s2_vs_q     <= s1_vs_q;
      s2_de_q     <= s1_de_q;
      s2_in_box_q <= axis_hit[0] && axis_hit[1];
    end
  end

  // Stage 3: registered outputs; video is black outside the active area.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_hs    <= 1'b0;
      o_vs    <= 1'b0;
      o_de    <= 1'b0;
      o_video <= 24'h0;
    end else begin
      o_hs    <= s2_hs_q;
      o_vs    <= s2_vs_q;
      o_de    <= s2_de_q;
      o_video <= s2_de_q ? (s2_in_box_q ? FG_COLOR : BG_COLOR) : 24'h0;
    end
  end

endmodule

// File: tb/tb_hvtx_box_gen.sv
`timescale 1ns/1ps
// Bench for hvtx_box_gen: two instances share the same stimulus, one with the
// default 1920x1080 geometry and one small 43x30 area with STEP=7 and
// FRAMES_PER_STEP=3, each followed by a behavioural model.
module tb_hvtx_box_gen;

  localparam logic [23:0] FG = 24'h00f0f0;
  localparam logic [23:0] BG = 24'hc0c0c0;

  localparam int M_W    [2] = '{1920, 43};
  localparam int M_H    [2] = '{1080, 30};
  localparam int M_STEP [2] = '{10, 7};
  localparam int M_FPS  [2] = '{1, 3};
  localparam int M_BOX      = 10;

  logic        clk = 1'b0;
  logic        rst, en, hs, vs, de;
  logic [11:0] x, y;

  logic        o_hs_w [2];
  logic        o_vs_w [2];
  logic        o_de_w [2];
  logic [23:0] o_vid_w[2];
  logic [11:0] o_bx_w [2];
  logic [11:0] o_by_w [2];

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  hvtx_box_gen dut_a (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_x(x), .i_y(y),
    .i_hs(hs), .i_vs(vs), .i_de(de),
    .o_hs(o_hs_w[0]), .o_vs(o_vs_w[0]), .o_de(o_de_w[0]), .o_video(o_vid_w[0]),
    .o_box_x(o_bx_w[0]), .o_box_y(o_by_w[0])
  );

  hvtx_box_gen #(
    .ACTIVE_WIDTH(43), .ACTIVE_HEIGHT(30), .BOX_SIZE(10), .STEP(7), .FRAMES_PER_STEP(3)
  ) dut_b (
    .i_clk(clk), .i_rst(rst), .i_en(en), .i_x(x), .i_y(y),
    .i_hs(hs), .i_vs(vs), .i_de(de),
    .o_hs(o_hs_w[1]), .o_vs(o_vs_w[1]), .o_de(o_de_w[1]), .o_video(o_vid_w[1]),
    .o_box_x(o_bx_w[1]), .o_box_y(o_by_w[1])
  );

  // ---------------- behavioural model ----------------
  int          bx[2], by[2], fc[2];
  bit          nx[2], ny[2];
  bit          vprev;
  logic [26:0] pipe[2][3];   // {hs, vs, de, video}, index 2 is the oldest

  task automatic model_reset();
    vprev = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bx[i] = 0; by[i] = 0; fc[i] = 0; nx[i] = 1'b0; ny[i] = 1'b0;
      for (int k = 0; k < 3; k++) pipe[i][k] = '0;
    end
  endtask

  task automatic move(input int pos, input bit neg, input int mx, input int st,
                      output int npos, output bit nneg);
    if (!neg) begin
      if (pos + st >= mx) begin npos = mx; nneg = 1'b1; end
      else                begin npos = pos + st; nneg = 1'b0; end
    end else begin
      if (pos <= st) begin npos = 0; nneg = 1'b0; end
      else           begin npos = pos - st; nneg = 1'b1; end
    end
  endtask

  task automatic model_cycle();
    bit          rise;
    bit          inbox;
    logic [23:0] vid;
    rise  = vs && !vprev;
    vprev = vs;
    for (int i = 0; i < 2; i++) begin
      if (rise && en) begin
        if (fc[i] == M_FPS[i] - 1) begin
          fc[i] = 0;
          move(bx[i], nx[i], M_W[i] - M_BOX, M_STEP[i], bx[i], nx[i]);
          move(by[i], ny[i], M_H[i] - M_BOX, M_STEP[i], by[i], ny[i]);
        end else begin
          fc[i] = fc[i] + 1;
        end
      end
      inbox = (int'(x) >= bx[i]) && (int'(x) < bx[i] + M_BOX) &&
              (int'(y) >= by[i]) && (int'(y) < by[i] + M_BOX);
      vid = de ? (inbox ? FG : BG) : 24'h0;
      pipe[i][2] = pipe[i][1];
      pipe[i][1] = pipe[i][0];
      pipe[i][0] = {hs, vs, de, vid};
    end
  endtask

  // Full per-cycle comparison of both instances against the model.
  task automatic compare_all();
    logic [26:0] got;
    for (int i = 0; i < 2; i++) begin
      got = {o_hs_w[i], o_vs_w[i], o_de_w[i], o_vid_w[i]};
      vectors++;
      if (got !== pipe[i][2] || o_bx_w[i] !== 12'(bx[i]) || o_by_w[i] !== 12'(by[i])) begin
        miscompares++;
        $display("FAIL cycle inst%0d t=%0t: got hs/vs/de=%b%b%b video=%h box=(%0d,%0d) want hs/vs/de=%b%b%b video=%h box=(%0d,%0d)",
                 i, $time, got[26], got[25], got[24], got[23:0], o_bx_w[i], o_by_w[i],
                 pipe[i][2][26], pipe[i][2][25], pipe[i][2][24], pipe[i][2][23:0], bx[i], by[i]);
      end
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h", name, got, exp);
    end
  endtask

  // One clock: model and DUTs both see the inputs at the edge, outputs are
  // checked 1 ns later.
  task automatic cyc();
    @(posedge clk);
    #1;
    if (rst) model_reset();
    else     model_cycle();
    compare_all();
  endtask

  task automatic pulse_vs();
    de = 1'b0; hs = 1'b0; vs = 1'b1;
    repeat (4) cyc();
    vs = 1'b0;
    repeat (2) cyc();
  endtask

  // ---------------- directed pixel vectors ----------------
  typedef struct {
    logic [11:0] vx, vy;
    logic        vhs, vde;
    logic [23:0] exp_video;
    logic        exp_hs, exp_de;
  } vec_t;

  vec_t vt[8];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int n;
    int bound;
    int t;
    int r;

    vt[0] = '{12'd0,  12'd0,  1'b0, 1'b1, FG,    1'b0, 1'b1};
    vt[1] = '{12'd10, 12'd0,  1'b0, 1'b1, BG,    1'b0, 1'b1};
    vt[2] = '{12'd9,  12'd9,  1'b0, 1'b1, FG,    1'b0, 1'b1};
    vt[3] = '{12'd0,  12'd0,  1'b0, 1'b0, 24'h0, 1'b0, 1'b0};
    vt[4] = '{12'd0,  12'd10, 1'b1, 1'b1, BG,    1'b1, 1'b1};
    vt[5] = '{12'd5,  12'd5,  1'b1, 1'b1, FG,    1'b1, 1'b1};
    vt[6] = '{12'd9,  12'd10, 1'b0, 1'b1, BG,    1'b0, 1'b1};
    vt[7] = '{12'd4,  12'd0,  1'b1, 1'b0, 24'h0, 1'b1, 1'b0};
    n = 8;

    rst = 1'b1; en = 1'b1; hs = 1'b0; vs = 1'b0; de = 1'b0; x = '0; y = '0;
    model_reset();
    repeat (2) cyc();
    chk("reset video", {8'h0, o_vid_w[0]}, 32'h0);
    chk("reset box_x", {20'h0, o_bx_w[0]}, 32'h0);
    rst = 1'b0;

    // Table: each vector must reach the outputs exactly 3 edges later.
    x = vt[0].vx; y = vt[0].vy; hs = vt[0].vhs; de = vt[0].vde;
    for (int j = 0; j < n + 2; j++) begin
      cyc();
      if (j >= 2) begin
        for (int i = 0; i < 2; i++) begin
          chk($sformatf("table%0d inst%0d video", j - 2, i), {8'h0, o_vid_w[i]}, {8'h0, vt[j-2].exp_video});
          chk($sformatf("table%0d inst%0d hs/de", j - 2, i), {30'h0, o_hs_w[i], o_de_w[i]},
              {30'h0, vt[j-2].exp_hs, vt[j-2].exp_de});
        end
      end
      if (j + 1 < n) begin
        x = vt[j+1].vx; y = vt[j+1].vy; hs = vt[j+1].vhs; de = vt[j+1].vde;
      end else begin
        x = '0; y = '0; hs = 1'b0; de = 1'b0;
      end
    end

    // First vsync pulse: A steps once, visible right after the rising edge.
    vs = 1'b1;
    cyc();
    chk("first tick box_x", {20'h0, o_bx_w[0]}, 32'd10);
    chk("first tick box_y", {20'h0, o_by_w[0]}, 32'd10);
    repeat (3) cyc();
    vs = 1'b0;
    repeat (2) cyc();
    chk("one step per pulse", {20'h0, o_bx_w[0]}, 32'd10);
    chk("B no step on 1st tick", {20'h0, o_bx_w[1]}, 32'd0);

    // Pulses 2..27: B takes 9 steps, landing at x=5 heading left.
    repeat (26) pulse_vs();
    chk("A x after 27", {20'h0, o_bx_w[0]}, 32'd270);
    chk("B x after 27", {20'h0, o_bx_w[1]}, 32'd5);
    chk("B y after 27", {20'h0, o_by_w[1]}, 32'd20);
    pulse_vs();
    chk("B held on 28", {20'h0, o_bx_w[1]}, 32'd5);

    // Movement disabled for 5 pulses; A and B frame counts must hold.
    en = 1'b0;
    repeat (5) pulse_vs();
    chk("A frozen", {20'h0, o_bx_w[0]}, 32'd280);
    chk("B frozen", {20'h0, o_bx_w[1]}, 32'd5);
    en = 1'b1;
    pulse_vs();
    chk("B held on 29", {20'h0, o_bx_w[1]}, 32'd5);
    pulse_vs();
    chk("B left clamp x", {20'h0, o_bx_w[1]}, 32'd0);
    chk("B y on 30", {20'h0, o_by_w[1]}, 32'd13);
    chk("A x on 30", {20'h0, o_bx_w[0]}, 32'd300);
    repeat (3) pulse_vs();
    chk("B after clamp x", {20'h0, o_bx_w[1]}, 32'd7);
    chk("B after clamp y", {20'h0, o_by_w[1]}, 32'd6);

    // Bottom bounce on A.
    bound = 0;
    while (!(by[0] == 1060 && !ny[0]) && bound < 300) begin pulse_vs(); bound++; end
    chk("bottom reach bound", {31'h0, bound < 300}, 32'd1);
    pulse_vs();
    chk("bottom bounce 1070", {20'h0, o_by_w[0]}, 32'd1070);
    pulse_vs();
    chk("bottom back 1060", {20'h0, o_by_w[0]}, 32'd1060);

    // Right bounce on A.
    bound = 0;
    while (!(bx[0] == 1900 && !nx[0]) && bound < 300) begin pulse_vs(); bound++; end
    chk("right reach bound", {31'h0, bound < 300}, 32'd1);
    pulse_vs();
    chk("right bounce 1910", {20'h0, o_bx_w[0]}, 32'd1910);
    pulse_vs();
    chk("right back 1900", {20'h0, o_bx_w[0]}, 32'd1900);

    // Random traffic, pixels biased towards one of the boxes.
    for (int c = 0; c < 1500; c++) begin
      t = $urandom_range(0, 1);
      r = bx[t] + $urandom_range(0, 14) - 2;
      x = 12'((r < 0) ? 0 : r);
      r = by[t] + $urandom_range(0, 14) - 2;
      y = 12'((r < 0) ? 0 : r);
      de = ($urandom_range(0, 3) != 0);
      hs = ($urandom_range(0, 7) == 0);
      vs = ($urandom_range(0, 11) == 0);
      en = ($urandom_range(0, 3) != 0);
      cyc();
    end

    // Reset, move to (40,40), then reset asynchronously mid-line.
    rst = 1'b1; vs = 1'b0; de = 1'b0; hs = 1'b0; en = 1'b1;
    cyc();
    rst = 1'b0;
    repeat (4) pulse_vs();
    chk("pre-reset box_x", {20'h0, o_bx_w[0]}, 32'd40);
    chk("pre-reset box_y", {20'h0, o_by_w[0]}, 32'd40);
    x = 12'd40; y = 12'd40; de = 1'b1;
    repeat (4) cyc();
    chk("pre-reset video", {8'h0, o_vid_w[0]}, {8'h0, FG});
    #3;
    rst = 1'b1;
    #1;
    chk("async video", {8'h0, o_vid_w[0]}, 32'h0);
    chk("async de", {31'h0, o_de_w[0]}, 32'h0);
    chk("async box_x", {20'h0, o_bx_w[0]}, 32'h0);
    chk("async box_y B", {20'h0, o_by_w[1]}, 32'h0);
    model_reset();
    cyc();
    rst = 1'b0; x = '0; y = '0; de = 1'b1;
    cyc();
    chk("refill de 1", {31'h0, o_de_w[0]}, 32'h0);
    cyc();
    chk("refill de 2", {31'h0, o_de_w[0]}, 32'h0);
    cyc();
    chk("refill video", {8'h0, o_vid_w[0]}, {8'h0, FG});
    chk("refill de 3", {31'h0, o_de_w[0]}, 32'h1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
